// File: rtl/traffic_light_fsm_if.sv
// Sequencer-side bundle: timer handshake, synchronized inputs and lamp outputs.
// master = traffic_light_fsm, slave = timer/input/LED environment.
interface traffic_light_fsm_if;
   logic       Sensor_Sync;
   logic       WR;
   logic       Prog_Sync;
   logic       expired;
   logic [1:0] interval;
   logic       start_timer;
   logic       WR_Reset;
   logic [6:0] LEDs;

   modport master (
      input  Sensor_Sync, WR, Prog_Sync, expired,
      output interval, start_timer, WR_Reset, LEDs
   );

   modport slave (
      output Sensor_Sync, WR, Prog_Sync, expired,
      input  interval, start_timer, WR_Reset, LEDs
   );
endinterface

// File: rtl/traffic_light_fsm.sv
// Intersection sequencer: steps the lamp phases on timer expiry and reloads the timer.
// Optional side-street sensor extension phase enabled by defining SIDE_SENSOR_EXT_EN.
module traffic_light_fsm #(
   parameter logic [1:0] INT_BASE = 2'b00,
   parameter logic [1:0] INT_EXT  = 2'b01,
   parameter logic [1:0] INT_YEL  = 2'b10
) (
   input  logic                       clk,
   input  logic                       Reset_Sync,
   traffic_light_fsm_if.master        bus
);
   localparam logic [2:0] MG_A = 3'd0;
   localparam logic [2:0] MG_B = 3'd1;
   localparam logic [2:0] MY   = 3'd2;
   localparam logic [2:0] WALK = 3'd3;
   localparam logic [2:0] SG_A = 3'd4;
`ifdef SIDE_SENSOR_EXT_EN
   localparam logic [2:0] SG_B = 3'd5;
`endif
   localparam logic [2:0] SY   = 3'd6;

   logic [2:0] state_reg, state_next;
   logic [1:0] interval_reg, interval_next;
   logic [6:0] leds_reg, leds_next;
   logic       start_reg, start_next;
   logic       wr_reset_reg, wr_reset_next;
   logic       rst_seen_reg;
   logic       load;

   always_comb begin
      state_next = state_reg;
      load       = 1'b0;
      if (bus.Prog_Sync) begin
         state_next = MG_A;
         load       = 1'b1;
      end else begin
         case (state_reg)
            MG_A: if (bus.expired) begin state_next = MG_B; load = 1'b1; end
            MG_B: if (bus.expired) begin state_next = MY;   load = 1'b1; end
            MY:   if (bus.expired) begin state_next = bus.WR ? WALK : SG_A; load = 1'b1; end
            WALK: if (bus.expired) begin state_next = SG_A; load = 1'b1; end
`ifdef SIDE_SENSOR_EXT_EN
            SG_A: if (bus.expired) begin state_next = bus.Sensor_Sync ? SG_B : SY; load = 1'b1; end
            SG_B: if (bus.expired) begin state_next = SY;   load = 1'b1; end
`else
            SG_A: if (bus.expired) begin state_next = SY;   load = 1'b1; end
`endif
            SY:   if (bus.expired) begin state_next = MG_A; load = 1'b1; end
            default: begin state_next = MG_A; load = 1'b1; end
         endcase
      end
   end

   // Interval is only re-selected on a load so sensor changes mid-interval have no effect.
   always_comb begin
      interval_next = interval_reg;
      if (load) begin
         case (state_next)
            MG_B:    interval_next = bus.Sensor_Sync ? INT_EXT : INT_BASE;
            MY:      interval_next = INT_YEL;
            WALK:    interval_next = INT_EXT;
`ifdef SIDE_SENSOR_EXT_EN
            SG_B:    interval_next = INT_EXT;
`endif
            SY:      interval_next = INT_YEL;
            default: interval_next = INT_BASE;
         endcase
      end
   end

   always_comb begin
      case (state_next)
         MY:      leds_next = 7'b0101000;
         WALK:    leds_next = 7'b1001001;
         SG_A:    leds_next = 7'b1000010;
`ifdef SIDE_SENSOR_EXT_EN
         SG_B:    leds_next = 7'b1000010;
`endif
         SY:      leds_next = 7'b1000100;
         default: leds_next = 7'b0011000;
      endcase
   end

   assign start_next    = load | rst_seen_reg;
   assign wr_reset_next = load && (state_next == WALK) && !bus.Prog_Sync;

   always_ff @(posedge clk) begin
      if (Reset_Sync) begin
         state_reg    <= MG_A;
         interval_reg <= INT_BASE;
         leds_reg     <= 7'b0011000;
         start_reg    <= 1'b0;
         wr_reset_reg <= 1'b0;
         rst_seen_reg <= 1'b1;
      end else begin
         state_reg    <= state_next;
         interval_reg <= interval_next;
         leds_reg     <= leds_next;
         start_reg    <= start_next;
         wr_reset_reg <= wr_reset_next;
         rst_seen_reg <= 1'b0;
      end
   end

   assign bus.interval    = interval_reg;
   assign bus.start_timer = start_reg;
   assign bus.WR_Reset    = wr_reset_reg;
   assign bus.LEDs        = leds_reg;
endmodule

// File: tb/tb_traffic_light_fsm.sv
// Directed bench for traffic_light_fsm: phase-table model checked every cycle plus literal pins.
// Build with SIDE_SENSOR_EXT_EN defined to exercise the side-street extension phase.
module tb_traffic_light_fsm;
   logic clk = 1'b0;
   logic Reset_Sync;
   int   total = 0;
   int   bad   = 0;
   bit   check_en = 1'b0;

   traffic_light_fsm_if bus ();

   traffic_light_fsm dut (
      .clk        (clk),
      .Reset_Sync (Reset_Sync),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   // Phase indices of the model; lamp and interval tables indexed by phase.
   localparam int P_MGA = 0, P_MGB = 1, P_MY = 2, P_WALK = 3, P_SGA = 4, P_SGB = 5, P_SY = 6;
   logic [6:0] lamp [7] = '{7'b0011000, 7'b0011000, 7'b0101000, 7'b1001001,
                            7'b1000010, 7'b1000010, 7'b1000100};

   int         m_phase = P_MGA;
   logic [1:0] m_int   = 2'b00;
   logic       m_start = 1'b0;
   logic       m_wrr   = 1'b0;
   logic       m_prev_rst = 1'b1;

   task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%b required=%b", name, act, exp);
      end
   endtask

   // Model: next phase follows the listed phase order, with walk/sensor branches.
   always @(posedge clk) begin : model
      int nph;
      logic [1:0] nint;
      logic nst, nwr;
      nph = m_phase; nint = m_int; nst = 1'b0; nwr = 1'b0;
      if (Reset_Sync) begin
         nph = P_MGA; nint = 2'b00;
      end else begin
         nst = m_prev_rst;
         if (bus.Prog_Sync) begin
            nph = P_MGA; nint = 2'b00; nst = 1'b1;
         end else if (bus.expired) begin
            nst = 1'b1;
            case (m_phase)
               P_MGA: begin nph = P_MGB; nint = bus.Sensor_Sync ? 2'b01 : 2'b00; end
               P_MGB: begin nph = P_MY;  nint = 2'b10; end
               P_MY:  begin nph = bus.WR ? P_WALK : P_SGA; nint = bus.WR ? 2'b01 : 2'b00; nwr = bus.WR; end
               P_WALK: begin nph = P_SGA; nint = 2'b00; end
`ifdef SIDE_SENSOR_EXT_EN
               P_SGA: begin nph = bus.Sensor_Sync ? P_SGB : P_SY; nint = bus.Sensor_Sync ? 2'b01 : 2'b10; end
`else
               P_SGA: begin nph = P_SY;  nint = 2'b10; end
`endif
               P_SGB: begin nph = P_SY;  nint = 2'b10; end
               default: begin nph = P_MGA; nint = 2'b00; end
            endcase
         end
      end
      m_phase    <= nph;
      m_int      <= nint;
      m_start    <= nst;
      m_wrr      <= nwr;
      m_prev_rst <= Reset_Sync;
   end

   always @(negedge clk) begin
      if (check_en) begin
         chk("cyc_leds", bus.LEDs, lamp[m_phase]);
         chk("cyc_interval", {5'b0, bus.interval}, {5'b0, m_int});
         chk("cyc_start", {6'b0, bus.start_timer}, {6'b0, m_start});
         chk("cyc_wr_reset", {6'b0, bus.WR_Reset}, {6'b0, m_wrr});
         chk("cyc_conflict", {6'b0, ((bus.LEDs[5] | bus.LEDs[4]) & (bus.LEDs[2] | bus.LEDs[1]))
             | (bus.LEDs[0] & ~(bus.LEDs[6] & bus.LEDs[3]))}, 7'b0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input string name, input logic [6:0] leds, input logic [1:0] intv);
      bus.expired = 1'b1;
      tick();
      bus.expired = 1'b0;
      chk({name, "_leds"}, bus.LEDs, leds);
      chk({name, "_int"}, {5'b0, bus.interval}, {5'b0, intv});
      chk({name, "_start"}, {6'b0, bus.start_timer}, 7'd1);
      $display("expired -> %s leds=%b interval=%b", name, bus.LEDs, bus.interval);
      tick();
      tick();
   endtask

   initial begin
      Reset_Sync = 1'b1;
      bus.Sensor_Sync = 1'b0; bus.WR = 1'b0; bus.Prog_Sync = 1'b0; bus.expired = 1'b0;
      tick(); tick();
      chk("rst_leds", bus.LEDs, 7'b0011000);
      chk("rst_int", {5'b0, bus.interval}, 7'd0);
      chk("rst_start", {6'b0, bus.start_timer}, 7'd0);
      $display("reset held: leds=%b start=%b", bus.LEDs, bus.start_timer);
      check_en = 1'b1;
      Reset_Sync = 1'b0;
      tick();
      chk("rel_start", {6'b0, bus.start_timer}, 7'd1);
      tick();
      chk("rel_start_drop", {6'b0, bus.start_timer}, 7'd0);
      $display("reset released: start pulse seen");

      // plain cycle
      pulse("MG_B", 7'b0011000, 2'b00);
      pulse("MY",   7'b0101000, 2'b10);
      pulse("SG_A", 7'b1000010, 2'b00);
      pulse("SY",   7'b1000100, 2'b10);
      pulse("MG_A", 7'b0011000, 2'b00);

      // sensor extension on main street, then sensor ignored mid-interval
      bus.Sensor_Sync = 1'b1;
      pulse("MG_B_ext", 7'b0011000, 2'b01);
      bus.Sensor_Sync = 1'b0;
      pulse("MY", 7'b0101000, 2'b10);
      pulse("SG_A", 7'b1000010, 2'b00);
      pulse("SY", 7'b1000100, 2'b10);
      pulse("MG_A", 7'b0011000, 2'b00);
      pulse("MG_B_noext", 7'b0011000, 2'b00);
      bus.Sensor_Sync = 1'b1;
      tick(); tick();
      chk("mid_sensor_int", {5'b0, bus.interval}, 7'd0);
      bus.Sensor_Sync = 1'b0;

      // walk request
      pulse("MY", 7'b0101000, 2'b10);
      bus.WR = 1'b1;
      bus.expired = 1'b1;
      tick();
      bus.expired = 1'b0;
      chk("walk_leds", bus.LEDs, 7'b1001001);
      chk("walk_int", {5'b0, bus.interval}, 7'd1);
      chk("walk_wr_reset", {6'b0, bus.WR_Reset}, 7'd1);
      chk("walk_start", {6'b0, bus.start_timer}, 7'd1);
      $display("expired -> WALK leds=%b wr_reset=%b", bus.LEDs, bus.WR_Reset);
      bus.WR = 1'b0;
      tick();
      chk("walk_wr_reset_drop", {6'b0, bus.WR_Reset}, 7'd0);
      tick();
      pulse("SG_A", 7'b1000010, 2'b00);

      // side-street sensor at SG_A exit
      bus.Sensor_Sync = 1'b1;
`ifdef SIDE_SENSOR_EXT_EN
      pulse("SG_B", 7'b1000010, 2'b01);
      bus.Sensor_Sync = 1'b0;
      pulse("SY", 7'b1000100, 2'b10);
`else
      pulse("SY_direct", 7'b1000100, 2'b10);
      bus.Sensor_Sync = 1'b0;
`endif

      // reprogram during SY with expired held
      bus.Prog_Sync = 1'b1;
      bus.expired = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("prog_leds", bus.LEDs, 7'b0011000);
         chk("prog_int", {5'b0, bus.interval}, 7'd0);
         chk("prog_start", {6'b0, bus.start_timer}, 7'd1);
         $display("prog cycle %0d: leds=%b start=%b", i, bus.LEDs, bus.start_timer);
      end
      bus.Prog_Sync = 1'b0;
      bus.expired = 1'b0;
      tick();
      chk("prog_end_start", {6'b0, bus.start_timer}, 7'd0);
      chk("prog_end_leds", bus.LEDs, 7'b0011000);
      tick();
      pulse("MG_B_after_prog", 7'b0011000, 2'b00);

      // reset mid-interval drops a pending walk
      pulse("MY", 7'b0101000, 2'b10);
      bus.WR = 1'b1;
      Reset_Sync = 1'b1;
      bus.expired = 1'b1;
      tick();
      bus.expired = 1'b0;
      chk("midrst_leds", bus.LEDs, 7'b0011000);
      chk("midrst_start", {6'b0, bus.start_timer}, 7'd0);
      chk("midrst_wr_reset", {6'b0, bus.WR_Reset}, 7'd0);
      Reset_Sync = 1'b0;
      bus.WR = 1'b0;
      tick();
      chk("midrst_rel_start", {6'b0, bus.start_timer}, 7'd1);
      $display("reset mid-interval: leds=%b", bus.LEDs);
      tick();
      pulse("MG_B_after_rst", 7'b0011000, 2'b00);

      check_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
